// File: rtl/cr16_alu_writeback.sv
// CR16 ALU result consumer: masked PSR flag update, branch condition evaluation, and a writeback FIFO.
// Accepted results appear on the FIFO head and O_psr one cycle later; O_ready is low whenever the FIFO is full.
module cr16_alu_writeback #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2
) (
  input  logic                  I_clk,
  input  logic                  I_reset,
  input  logic                  I_valid,
  output logic                  O_ready,
  input  logic [DATA_WIDTH-1:0] I_dest,
  input  logic [4:0]            I_flags,
  input  logic [4:0]            I_flag_mask,
  input  logic                  I_wb_en,
  input  logic [3:0]            I_wb_addr,
  output logic                  O_wb_valid,
  input  logic                  I_wb_ready,
  output logic [DATA_WIDTH-1:0] O_wb_data,
  output logic [3:0]            O_wb_addr,
  output logic [4:0]            O_psr,
  input  logic [3:0]            I_cond,
  output logic                  O_cond_true
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [3:0]            r_mem_addr [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [4:0]            r_psr;

  logic w_full;
  logic w_accept;
  logic w_push;
  logic w_pop;

  // Full blocks every accept, including flag-only ones, independent of a same-edge pop.
  assign w_full     = (r_count == CW'(DEPTH));
  assign O_ready    = !w_full;
  assign w_accept   = I_valid && O_ready;
  assign w_push     = w_accept && I_wb_en;
  assign O_wb_valid = (r_count != '0);
  assign w_pop      = O_wb_valid && I_wb_ready;

  assign O_wb_data  = r_mem_data[r_rptr];
  assign O_wb_addr  = r_mem_addr[r_rptr];
  assign O_psr      = r_psr;

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_psr   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_addr[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_psr <= (r_psr & ~I_flag_mask) | (I_flags & I_flag_mask);
      end
      if (w_push) begin
        r_mem_data[r_wptr] <= I_dest;
        r_mem_addr[r_wptr] <= I_wb_addr;
        r_wptr             <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  logic w_c, w_l, w_f, w_z, w_n;
  assign w_c = r_psr[4];
  assign w_l = r_psr[3];
  assign w_f = r_psr[2];
  assign w_z = r_psr[1];
  assign w_n = r_psr[0];

  always_comb begin
    O_cond_true = 1'b0;
    case (I_cond)
      4'b0000: O_cond_true = w_z;
      4'b0001: O_cond_true = !w_z;
      4'b0010: O_cond_true = w_c;
      4'b0011: O_cond_true = !w_c;
      4'b0100: O_cond_true = w_l;
      4'b0101: O_cond_true = !w_l;
      4'b0110: O_cond_true = w_n;
      4'b0111: O_cond_true = !w_n;
      4'b1000: O_cond_true = w_f;
      4'b1001: O_cond_true = !w_f;
      4'b1010: O_cond_true = !w_l && !w_z;
      4'b1011: O_cond_true = w_l || w_z;
      4'b1100: O_cond_true = !w_n && !w_z;
      4'b1101: O_cond_true = w_n || w_z;
      4'b1110: O_cond_true = 1'b1;
      default: O_cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cr16_alu_writeback.sv
// Directed bench: stimulus pushes expected writes into a queue, a negedge monitor pops and compares.
module tb_cr16_alu_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready;
  logic [15:0] dest;
  logic [4:0]  flags;
  logic [4:0]  mask;
  logic        wb_en;
  logic [3:0]  wb_addr_in;
  logic        wb_valid;
  logic        wb_ready;
  logic [15:0] wb_data;
  logic [3:0]  wb_addr;
  logic [4:0]  psr;
  logic [3:0]  cond;
  logic        cond_true;

  int checks = 0;
  int errors = 0;
  int n_pops = 0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  cr16_alu_writeback #(.DATA_WIDTH(16), .DEPTH(2)) dut (
    .I_clk       (clk),
    .I_reset     (rst),
    .I_valid     (valid),
    .O_ready     (ready),
    .I_dest      (dest),
    .I_flags     (flags),
    .I_flag_mask (mask),
    .I_wb_en     (wb_en),
    .I_wb_addr   (wb_addr_in),
    .O_wb_valid  (wb_valid),
    .I_wb_ready  (wb_ready),
    .O_wb_data   (wb_data),
    .O_wb_addr   (wb_addr),
    .O_psr       (psr),
    .I_cond      (cond),
    .O_cond_true (cond_true)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one result for a single cycle; expected writes go to the scoreboard.
  task automatic issue(input logic [15:0] d, input logic [3:0] a, input logic [4:0] f,
                       input logic [4:0] m, input logic en);
    valid = 1'b1; dest = d; wb_addr_in = a; flags = f; mask = m; wb_en = en;
    if (en) exp_q.push_back({d, a});
    tick();
    valid = 1'b0; wb_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && wb_valid === 1'b1 && wb_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", {12'h0, wb_data, wb_addr}, 32'hFFFF_FFFF);
      end else begin
        check("pop_data", {12'h0, wb_data, wb_addr}, {12'h0, exp_q.pop_front()});
        n_pops++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_all0;
    logic [15:0] exp_all1;
    exp_all0 = 16'b0101_0110_1010_1010;
    exp_all1 = 16'b0110_1001_0101_0101;
    rst = 1'b1; valid = 1'b0; dest = '0; flags = '0; mask = '0; wb_en = 1'b0;
    wb_addr_in = '0; wb_ready = 1'b0; cond = 4'b0000;
    tick(); tick();
    rst = 1'b0;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_psr", 32'(psr), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_wb_addr", 32'(wb_addr), 32'd0);

    // Basic accept, monitor checks 0x0005@3.
    wb_ready = 1'b1;
    issue(16'h0005, 4'd3, 5'b00010, 5'b11111, 1'b1);
    check("t1_wb_valid", 32'(wb_valid), 32'd1);
    check("t1_psr", 32'(psr), 32'h02);
    cond = 4'b0000; #1;
    check("t1_eq", 32'(cond_true), 32'd1);
    tick();
    check("t1_drained", 32'(wb_valid), 32'd0);

    // Partial mask, flag-only ops.
    issue(16'h0, 4'd0, 5'b11111, 5'b11111, 1'b0);
    check("t2_psr_all", 32'(psr), 32'h1F);
    issue(16'h0, 4'd0, 5'b00000, 5'b00011, 1'b0);
    check("t2_psr_partial", 32'(psr), 32'h1C);
    check("t2_wb_valid", 32'(wb_valid), 32'd0);
    check("t2_ready", 32'(ready), 32'd1);

    // Backpressure to full.
    wb_ready = 1'b0;
    issue(16'h1111, 4'd1, 5'b00000, 5'b00000, 1'b1);
    check("t3_ready_one", 32'(ready), 32'd1);
    issue(16'h2222, 4'd2, 5'b00000, 5'b00000, 1'b1);
    check("t3_ready_full", 32'(ready), 32'd0);
    check("t3_head_data", 32'(wb_data), 32'h1111);
    check("t3_head_addr", 32'(wb_addr), 32'd1);
    valid = 1'b1; dest = 16'h3333; wb_addr_in = 4'd9; flags = 5'b00011; mask = 5'b11111; wb_en = 1'b1;
    tick();
    valid = 1'b0; wb_en = 1'b0;
    check("t3_full_psr_held", 32'(psr), 32'h1C);
    check("t3_full_head_held", 32'(wb_data), 32'h1111);
    wb_ready = 1'b1;
    tick();
    check("t3_ready_after_pop", 32'(ready), 32'd1);
    check("t3_head_next", 32'(wb_data), 32'h2222);
    tick();
    check("t3_empty", 32'(wb_valid), 32'd0);

    // Simultaneous push and pop with one entry present.
    wb_ready = 1'b0;
    issue(16'hAAAA, 4'd4, 5'b00000, 5'b00000, 1'b1);
    wb_ready = 1'b1;
    issue(16'hBBBB, 4'd5, 5'b00000, 5'b00000, 1'b1);
    check("t4_wb_valid", 32'(wb_valid), 32'd1);
    check("t4_ready", 32'(ready), 32'd1);
    check("t4_head", 32'(wb_data), 32'hBBBB);
    tick();
    check("t4_empty", 32'(wb_valid), 32'd0);

    // Condition sweeps.
    issue(16'h0, 4'd0, 5'b00000, 5'b11111, 1'b0);
    for (int i = 0; i < 16; i++) begin
      cond = 4'(i); #1;
      check($sformatf("cond_psr0_%0d", i), 32'(cond_true), 32'(exp_all0[i]));
    end
    issue(16'h0, 4'd0, 5'b11111, 5'b11111, 1'b0);
    for (int i = 0; i < 16; i++) begin
      cond = 4'(i); #1;
      check($sformatf("cond_psr1_%0d", i), 32'(cond_true), 32'(exp_all1[i]));
    end
    issue(16'h0, 4'd0, 5'b00010, 5'b11111, 1'b0);
    cond = 4'b1010; #1; check("cond_z_lo", 32'(cond_true), 32'd0);
    cond = 4'b1011; #1; check("cond_z_hs", 32'(cond_true), 32'd1);
    cond = 4'b1100; #1; check("cond_z_lt", 32'(cond_true), 32'd0);
    cond = 4'b1101; #1; check("cond_z_ge", 32'(cond_true), 32'd1);

    // Reset beats a same-edge accept with one entry queued.
    wb_ready = 1'b0;
    issue(16'h7777, 4'd7, 5'b00000, 5'b00000, 1'b1);
    exp_q.delete();
    rst = 1'b1;
    issue(16'h9999, 4'd9, 5'b11111, 5'b11111, 1'b1);
    exp_q.delete();
    rst = 1'b0;
    check("t6_psr", 32'(psr), 32'd0);
    check("t6_wb_valid", 32'(wb_valid), 32'd0);
    check("t6_ready", 32'(ready), 32'd1);
    check("t6_wb_data", 32'(wb_data), 32'd0);

    tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("pop_count", 32'(n_pops), 32'd5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cr16_alu_writeback.md
# cr16_alu_writeback

Result-consumer stage on the output side of the CR16 ALU. Accepts one ALU result per handshake: 16-bit destination value, 5-bit flag vector, per-flag update mask and register-file write request. Maintains the processor status register (PSR) flags and evaluates CR16 branch condition codes against them. Queues register-file writes in a small FIFO toward the register-file write port.

## Interface
- DATA_WIDTH, 16, width of ALU result and writeback data
- DEPTH, 2, writeback FIFO entries; power of two, >= 2
- I_clk  in  1  clock; all state updates on rising edge
- I_reset  in  1  synchronous, active-high reset
- I_valid  in  1  ALU result present
- O_ready  out  1  stage can accept a result this cycle
- I_dest  in  DATA_WIDTH  ALU result value
- I_flags  in  5  ALU flags: [4]=C, [3]=L, [2]=F, [1]=Z, [0]=N
- I_flag_mask  in  5  1 = update the corresponding PSR bit
- I_wb_en  in  1  result must be written to the register file
- I_wb_addr  in  4  destination register index
- O_wb_valid  out  1  FIFO head holds a pending write
- I_wb_ready  in  1  register file accepts the write this cycle
- O_wb_data  out  DATA_WIDTH  head entry value
- O_wb_addr  out  4  head entry register index
- O_psr  out  5  current flags, same bit order as I_flags
- I_cond  in  4  condition code to evaluate
- O_cond_true  out  1  I_cond satisfied by O_psr

## Operation
- Accept: I_valid && O_ready at a rising edge.
- O_ready = (count < DEPTH). It does not depend on I_wb_ready or I_valid.
- When full, O_ready is 0 even when a pop occurs that edge. This applies to flag-only ops as well.
- PSR update on accept: psr <= (psr & ~I_flag_mask) | (I_flags & I_flag_mask). It updates regardless of I_wb_en.
- Push on accept only when I_wb_en=1; store {I_dest, I_wb_addr} at the write pointer.
- Accept with I_wb_en=0 (CMP-style) consumes no FIFO entry.
- Pop: O_wb_valid && I_wb_ready; advance the read pointer.
- Pointers wrap modulo DEPTH. Count = number of stored entries, range 0..DEPTH.
- Simultaneous push and pop: count unchanged, both pointers advance. When count==DEPTH no push can occur.
- O_wb_valid = (count != 0). O_wb_data/O_wb_addr = head entry. They are held stable while O_wb_valid && !I_wb_ready.
- O_cond_true is combinational from O_psr and I_cond:
  - 0000 EQ: Z=1
  - 0001 NE: Z=0
  - 0010 CS: C=1
  - 0011 CC: C=0
  - 0100 HI: L=1
  - 0101 LS: L=0
  - 0110 GT: N=1
  - 0111 LE: N=0
  - 1000 FS: F=1
  - 1001 FC: F=0
  - 1010 LO: L=0 && Z=0
  - 1011 HS: L=1 || Z=1
  - 1100 LT: N=0 && Z=0
  - 1101 GE: N=1 || Z=1
  - 1110 UC: 1
  - 1111: 0
- Reset: psr=0, count=0, both pointers=0, all FIFO storage=0.
- Reset outputs: O_wb_valid=0, O_wb_data=0, O_wb_addr=0, O_psr=0, O_ready=1.
- Reset wins over an accept or pop on the same edge. An in-flight result is discarded and PSR is not updated.

## Timing
- Result accepted at edge N into an empty FIFO: O_wb_valid=1 with that entry during cycle N+1.
- PSR: new value is visible on O_psr and O_cond_true in cycle N+1.
- A result accepted at N is evaluated by I_cond in the cycle after N; no bypass of I_flags.
- Writes leave in acceptance order. Throughput is one result per cycle when I_wb_ready is held high.
- Back-to-back accepts at N and N+1 update PSR in order. A bit masked at N+1 keeps its value from N.
- O_ready falls in the cycle after the DEPTH-th outstanding push. It rises in the cycle after the first pop from full.

## Test plan
- Reset, then accept I_dest=0x0005, I_wb_addr=3, I_flags=5'b00010, mask=5'b11111, I_wb_en=1, I_wb_ready=1 -> next cycle O_wb_valid=1, O_wb_data=0x0005, O_wb_addr=3, O_psr=5'b00010; I_cond=0000 gives O_cond_true=1.
- Partial mask: PSR=5'b11111, accept I_flags=5'b00000, mask=5'b00011, I_wb_en=0 -> O_psr=5'b11100, FIFO count stays 0, O_wb_valid stays 0.
- Backpressure: I_wb_ready=0, accept 0x1111@r1 then 0x2222@r2 -> O_ready=0 after the second accept, head holds 0x1111@r1. Raise I_wb_ready -> pops 0x1111 then 0x2222 in order; O_ready=1 after the first pop.
- Simultaneous push/pop with one entry present -> count stays 1, head advances to the new entry next cycle, no data lost or duplicated.
- Condition sweep: for O_psr=5'b00000 and 5'b11111, all 16 I_cond values. Expected: LO=1/0, HS=0/1, UC=1/1, code 1111=0/0, others per the list.
- Reset asserted on the same edge as an accept of I_flags=5'b11111, mask=5'b11111 with one entry queued -> O_psr=0, O_wb_valid=0, O_ready=1 next cycle.
